// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : fetch_unit
// Description : Instruction-fetch stage. Owns the program counter, drives the
//               asynchronous instruction memory, and computes the next PC from
//               the decoder's jump / branch / halt controls. A jump-target LUT
//               expands the 6-bit JR immediate into a full PC. A run/halt FSM
//               and a saturating retired-instruction counter provide the
//               start/done handshake.
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_unit #(
    parameter int PC_WIDTH    = 10,
    parameter int INSTR_WIDTH = 9,
    parameter int LUT_DEPTH   = 64,
    parameter int CNT_WIDTH   = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    output logic [PC_WIDTH-1:0]    imem_addr,
    input  logic [INSTR_WIDTH-1:0] imem_rdata,
    output logic [INSTR_WIDTH-1:0] instr_out,
    output logic                   instr_valid,
    input  logic                   jump,
    input  logic [5:0]             jump_idx,
    input  logic                   branch_taken,
    input  logic                   halt,
    input  logic                   lut_we,
    input  logic [5:0]             lut_waddr,
    input  logic [PC_WIDTH-1:0]    lut_wdata,
    output logic [PC_WIDTH-1:0]    pc_out,
    output logic                   done,
    output logic [CNT_WIDTH-1:0]   instr_count
);

    localparam logic [1:0] c_ST_IDLE   = 2'd0;
    localparam logic [1:0] c_ST_RUN    = 2'd1;
    localparam logic [1:0] c_ST_HALTED = 2'd2;

    logic [1:0]           r_state;
    logic [1:0]           w_state_next;
    logic [PC_WIDTH-1:0]  r_pc;
    logic [PC_WIDTH-1:0]  w_pc_next;
    logic [CNT_WIDTH-1:0] r_cnt;
    logic [PC_WIDTH-1:0]  r_lut [0:LUT_DEPTH-1];
    logic                 w_run;
    logic                 w_done;
    logic                 w_launch;

    // State register; reset always returns to IDLE
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic; start is only meaningful outside RUN
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            c_ST_IDLE:   if (start) w_state_next = c_ST_RUN;
            c_ST_RUN:    if (halt)  w_state_next = c_ST_HALTED;
            c_ST_HALTED: if (start) w_state_next = c_ST_RUN;
            default:     w_state_next = c_ST_IDLE;
        endcase
    end

    // State-decoded outputs and the launch strobe that restarts execution
    always_comb begin
        w_run    = (r_state == c_ST_RUN);
        w_done   = (r_state == c_ST_HALTED);
        w_launch = (r_state != c_ST_RUN) && start;
    end

    // Next-PC selection: halt > jump > taken branch > sequential
    always_comb begin
        w_pc_next = r_pc;
        if (w_launch) begin
            w_pc_next = '0;
        end else if (w_run) begin
            if (halt) begin
                w_pc_next = r_pc;
            end else if (jump) begin
                w_pc_next = r_lut[jump_idx];
            end else if (branch_taken) begin
                // Wraps modulo 2^PC_WIDTH by truncation
                w_pc_next = r_pc + PC_WIDTH'(2);
            end else begin
                w_pc_next = r_pc + PC_WIDTH'(1);
            end
        end
    end

    // Program counter register
    always_ff @(posedge clk) begin
        if (reset) begin
            r_pc <= '0;
        end else begin
            r_pc <= w_pc_next;
        end
    end

    // Retired-instruction counter: counts every RUN cycle, saturates at max
    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt <= '0;
        end else if (w_launch) begin
            r_cnt <= '0;
        end else if (w_run && !(&r_cnt)) begin
            r_cnt <= r_cnt + CNT_WIDTH'(1);
        end
    end

    // Jump-target LUT: writable only while not executing; never reset so
    // targets survive a reset mid-program
    always_ff @(posedge clk) begin
        if (lut_we && !w_run) begin
            r_lut[lut_waddr] <= lut_wdata;
        end
    end

    assign imem_addr   = r_pc;
    assign instr_out   = imem_rdata;
    assign pc_out      = r_pc;
    assign instr_valid = w_run;
    assign done        = w_done;
    assign instr_count = r_cnt;

endmodule
`default_nettype wire
